// File: rtl/timer_pkg.sv
// Shared definitions for the AHB-Lite timer: register offsets, CTRL layout
// and AHB transfer-type decoding.
package timer_pkg;

    localparam logic [2:0] TIMER_CTRL     = 3'd0;
    localparam logic [2:0] TIMER_LOAD     = 3'd1;
    localparam logic [2:0] TIMER_VALUE    = 3'd2;
    localparam logic [2:0] TIMER_PRESCALE = 3'd3;
    localparam logic [2:0] TIMER_INTSTAT  = 3'd4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_IE       = 1;
    localparam int CTRL_PERIODIC = 2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Member order puts EN at bit 0, matching the CTRL_* indices.
    typedef struct packed {
        logic periodic;
        logic ie;
        logic en;
    } ctrl_t;

    function automatic logic trans_active(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/ahblite_timer_core.sv
// Prescaled 32-bit down-counter with one-shot/periodic reload and a sticky
// underflow status bit.
module ahblite_timer_core
    import timer_pkg::*;
(
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        en_i,
    input  logic        periodic_i,
    input  logic [7:0]  prescale_i,
    input  logic [31:0] load_i,
    input  logic        load_we_i,
    input  logic        int_clr_i,
    output logic [31:0] value_o,
    output logic        intstat_o,
    output logic        oneshot_done_o
);

    logic [7:0]  presc_q, presc_d;
    logic [31:0] value_q, value_d;
    logic        intstat_q, intstat_d;
    logic        tick;
    logic        underflow;

    assign tick      = en_i && (presc_q == prescale_i);
    // A LOAD write on the same edge overrides the whole tick.
    assign underflow = tick && (value_q == 32'd0) && !load_we_i;

    always_comb begin
        presc_d = presc_q;
        value_d = value_q;
        if (load_we_i) begin
            value_d = load_i;
            presc_d = 8'd0;
        end else if (en_i) begin
            presc_d = tick ? 8'd0 : presc_q + 8'd1;
            if (tick) begin
                if (value_q != 32'd0) begin
                    value_d = value_q - 32'd1;
                end else if (periodic_i) begin
                    value_d = load_i;
                end
            end
        end
        intstat_d = underflow ? 1'b1 : (int_clr_i ? 1'b0 : intstat_q);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            presc_q   <= 8'd0;
            value_q   <= 32'd0;
            intstat_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            value_q   <= value_d;
            intstat_q <= intstat_d;
        end
    end

    assign value_o        = value_q;
    assign intstat_o      = intstat_q;
    assign oneshot_done_o = underflow && !periodic_i;

endmodule

// File: rtl/ahblite_timer.sv
// AHB-Lite zero-wait-state slave wrapping the timer core: phase capture,
// register decode and read mux.
module ahblite_timer
    import timer_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              TIMER_IRQ
);

    logic        wr_q, rd_q, irq_q;
    logic [2:0]  addr_q;
    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [7:0]  prescale_q, prescale_d;
    logic        accept, load_we, int_clr;
    logic [31:0] value;
    logic        intstat, oneshot_done;
    logic        unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[ADDR_W-1:5], HADDR[1:0]};
    assign accept      = HSEL && HREADY && trans_active(HTRANS);
    assign load_we     = wr_q && (addr_q == TIMER_LOAD);
    assign int_clr     = wr_q && (addr_q == TIMER_INTSTAT) && HWDATA[0];

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_q && (addr_q == TIMER_CTRL)) begin
            ctrl_d = ctrl_t'(HWDATA[2:0]);
        end else if (oneshot_done) begin
            ctrl_d.en = 1'b0;
        end
        load_d     = load_we ? HWDATA : load_q;
        prescale_d = (wr_q && (addr_q == TIMER_PRESCALE)) ? HWDATA[7:0] : prescale_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= 3'd0;
            ctrl_q     <= '0;
            load_q     <= 32'd0;
            prescale_q <= 8'd0;
            irq_q      <= 1'b0;
        end else begin
            wr_q       <= accept && HWRITE;
            rd_q       <= accept && !HWRITE;
            if (accept) begin
                addr_q <= HADDR[4:2];
            end
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            prescale_q <= prescale_d;
            irq_q      <= intstat && ctrl_q[CTRL_IE];
        end
    end

    // load_d already carries HWDATA during a LOAD write, so it serves both
    // the immediate load and periodic reload.
    ahblite_timer_core u_core (
        .clk_i          (HCLK),
        .srst_i         (HRESET),
        .en_i           (ctrl_q[CTRL_EN]),
        .periodic_i     (ctrl_q[CTRL_PERIODIC]),
        .prescale_i     (prescale_q),
        .load_i         (load_d),
        .load_we_i      (load_we),
        .int_clr_i      (int_clr),
        .value_o        (value),
        .intstat_o      (intstat),
        .oneshot_done_o (oneshot_done)
    );

    always_comb begin
        HRDATA = 32'd0;
        if (rd_q) begin
            case (addr_q)
                TIMER_CTRL:     HRDATA = {29'd0, ctrl_q};
                TIMER_LOAD:     HRDATA = load_q;
                TIMER_VALUE:    HRDATA = value;
                TIMER_PRESCALE: HRDATA = {24'd0, prescale_q};
                TIMER_INTSTAT:  HRDATA = {31'd0, intstat};
                default:        HRDATA = 32'd0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign TIMER_IRQ = irq_q;

endmodule

// File: tb/tb_ahblite_timer.sv
// Self-checking bench for ahblite_timer: read expectations are queued at the
// address phase and compared when the data phase arrives.
module tb_ahblite_timer;

    logic        HCLK   = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL   = 1'b0;
    logic [11:0] HADDR  = 12'd0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE  = 3'b010;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = 32'd0;
    logic        HREADY = 1'b1;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        TIMER_IRQ;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t     sb_q[$];
    logic        pend_rd    = 1'b0;
    logic [31:0] pend_wdata = 32'd0;

    ahblite_timer #(.ADDR_W(12)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .TIMER_IRQ (TIMER_IRQ)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus cycle: drive an address phase (val = write data or expected
    // read data), drive HWDATA for the previous phase, check the data phase.
    task automatic step(input logic sel, input logic [1:0] trans, input logic rdy,
                        input logic wr, input logic [11:0] addr,
                        input logic [31:0] val, input string name);
        logic    dphase_rd;
        rd_exp_t e;
        dphase_rd  = pend_rd;
        HWDATA     = pend_wdata;
        HSEL       = sel;
        HTRANS     = trans;
        HREADY     = rdy;
        HWRITE     = wr;
        HADDR      = addr;
        pend_wdata = val;
        pend_rd    = sel && rdy && trans[1] && !wr && !HRESET;
        if (pend_rd) sb_q.push_back('{name, val});
        @(negedge HCLK);
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL bus_resp: got readyout=%b resp=%b want 1/0", HREADYOUT, HRESP);
        end
        checks++;
        if (dphase_rd) begin
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got no expectation want one");
            end else begin
                e = sb_q.pop_front();
                if (HRDATA !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", e.name, HRDATA, e.exp);
                end
            end
        end else if (HRDATA !== 32'd0) begin
            errors++;
            $display("FAIL idle_hrdata: got %h want 00000000", HRDATA);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        step(1'b1, 2'b10, 1'b1, 1'b1, addr, data, "write");
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
        step(1'b1, 2'b10, 1'b1, 1'b0, addr, exp, name);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 1'b1, 1'b0, 12'h000, 32'd0, "idle");
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            checks++;
            if (HRDATA !== 32'd0 || TIMER_IRQ !== 1'b0 || HREADYOUT !== 1'b1) begin
                errors++;
                $display("FAIL reset_outputs: got rdata=%h irq=%b ready=%b want 0/0/1",
                         HRDATA, TIMER_IRQ, HREADYOUT);
            end
        end
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        rd(12'h000, 32'd0, "reset_ctrl");
        rd(12'h004, 32'd0, "reset_load");
        rd(12'h008, 32'd0, "reset_value");
        rd(12'h00C, 32'd0, "reset_prescale");
        rd(12'h010, 32'd0, "reset_intstat");
        idle();
        checks++;
        if (TIMER_IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b want 0", TIMER_IRQ);
        end
    endtask

    task automatic test_idle();
        step(1'b0, 2'b10, 1'b1, 1'b1, 12'h004, 32'h0000_00AA, "unsel");
        step(1'b1, 2'b00, 1'b1, 1'b1, 12'h004, 32'h0000_00BB, "idle_trans");
        step(1'b1, 2'b10, 1'b0, 1'b1, 12'h000, 32'h0000_0007, "not_ready");
        rd(12'h004, 32'd0, "idle_load_unchanged");
        rd(12'h000, 32'd0, "idle_ctrl_unchanged");
        wr(12'h000, 32'hFFFF_FFF0);
        rd(12'h000, 32'd0, "ctrl_upper_bits");
        wr(12'h00C, 32'h0000_01FF);
        rd(12'h00C, 32'h0000_00FF, "prescale_width");
        wr(12'h00C, 32'd0);
        idle();
    endtask

    task automatic test_back_to_back();
        wr(12'h004, 32'h0000_0010);
        rd(12'h004, 32'h0000_0010, "b2b_load");
        rd(12'h008, 32'h0000_0010, "b2b_value");
        rd(12'h014, 32'd0, "unmapped_14");
        rd(12'h01C, 32'd0, "unmapped_1c");
        idle();
    endtask

    task automatic test_oneshot();
        logic        exp_irq;
        logic [31:0] exp_v;
        wr(12'h004, 32'd3);
        wr(12'h00C, 32'd0);
        wr(12'h000, 32'h3);
        for (int j = 0; j < 6; j++) begin
            exp_v = (j < 3) ? 32'(3 - j) : 32'd0;
            rd(12'h008, exp_v, $sformatf("oneshot_value[%0d]", j));
            exp_irq = (j >= 5);
            checks++;
            if (TIMER_IRQ !== exp_irq) begin
                errors++;
                $display("FAIL oneshot_irq[%0d]: got %b want %b", j, TIMER_IRQ, exp_irq);
            end
        end
        rd(12'h000, 32'h2, "oneshot_en_cleared");
        rd(12'h010, 32'h1, "oneshot_intstat");
        wr(12'h010, 32'h1);
        rd(12'h010, 32'h0, "oneshot_intstat_clr");
        idle();
        checks++;
        if (TIMER_IRQ !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_clr: got %b want 0", TIMER_IRQ);
        end
    endtask

    task automatic test_periodic();
        logic        exp_irq;
        logic [31:0] exp_v;
        wr(12'h004, 32'd2);
        wr(12'h00C, 32'd3);
        wr(12'h000, 32'h7);
        // Item j lands its data phase j cycles after EN takes effect;
        // underflow edges close cycles 11, 23, 35.
        for (int j = 0; j < 38; j++) begin
            exp_v = 32'(2 - ((j % 12) / 4));
            if (j == 24 || j == 35) begin
                wr(12'h010, 32'h1);
            end else if (j == 25) begin
                rd(12'h010, 32'h0, "periodic_intstat_clr");
            end else if (j == 36) begin
                rd(12'h010, 32'h1, "periodic_set_beats_clr");
            end else begin
                rd(12'h008, exp_v, $sformatf("periodic_value[%0d]", j));
            end
            exp_irq = (j >= 13 && j <= 25) || (j >= 37);
            checks++;
            if (TIMER_IRQ !== exp_irq) begin
                errors++;
                $display("FAIL periodic_irq[%0d]: got %b want %b", j, TIMER_IRQ, exp_irq);
            end
        end
        wr(12'h000, 32'h0);
        wr(12'h010, 32'h1);
        idle();
        idle();
        checks++;
        if (TIMER_IRQ !== 1'b0) begin
            errors++;
            $display("FAIL periodic_irq_off: got %b want 0", TIMER_IRQ);
        end
    endtask

    task automatic test_reset_mid_transfer();
        wr(12'h004, 32'h0000_0055);
        HRESET = 1'b1;
        idle();
        HRESET = 1'b0;
        rd(12'h004, 32'd0, "reset_drops_write");
        rd(12'h00C, 32'd0, "reset_clears_prescale");
        HRESET = 1'b1;
        wr(12'h004, 32'h0000_0066);
        HRESET = 1'b0;
        idle();
        rd(12'h004, 32'd0, "reset_addr_phase_dropped");
        idle();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_back_to_back();
        test_oneshot();
        test_periodic();
        test_reset_mid_transfer();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahblite_timer.md
# ahblite_timer

AHB-Lite slave that implements the TIMER peripheral behind the bus matrix TIMER output stage. It takes the address and data phases the matrix routes to the TIMER port and answers every transfer with zero wait states. It holds a prescaled 32-bit down-counter with one-shot and periodic modes and a level interrupt.

## Interface
Parameters:
- ADDR_W, 12: number of HADDR bits decoded; only HADDR[4:2] selects a register.

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  reset; synchronous, active-high.
- HSEL  in  1  slave select from the TIMER output stage.
- HADDR  in  ADDR_W  transfer address.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ or SEQ.
- HSIZE  in  3  transfer size; ignored, every access is treated as a word.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready; an address phase is taken only when this is 1.
- HREADYOUT  out  1  tied 1.
- HRESP  out  1  tied 0 (OKAY).
- HRDATA  out  32  read data for the current data phase.
- TIMER_IRQ  out  1  level interrupt.

## Operation
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. On that edge, latch wr_q=HWRITE, rd_q=~HWRITE and addr_q=HADDR[4:2]. Otherwise wr_q and rd_q are cleared on that edge.
- Write commit: on the edge that ends the data phase (wr_q=1), HWDATA is written to the register selected by addr_q.
- Read: while rd_q=1, HRDATA is driven combinationally from the registers selected by addr_q. Otherwise HRDATA is 0. Unmapped offsets read 0; writes to them are ignored.
- Register map (byte offsets):
  - 0x00 CTRL RW: [0] EN, [1] IE, [2] PERIODIC; other bits read 0.
  - 0x04 LOAD RW: a write also loads VALUE and clears the prescaler.
  - 0x08 VALUE RO.
  - 0x0C PRESCALE RW [7:0].
  - 0x10 INTSTAT: bit0 set by underflow; writing 1 to bit0 clears it.
- Counting:
  - While EN=1, the prescaler counts 0..PRESCALE and then issues a tick and returns to 0.
  - On a tick with VALUE≠0: VALUE decrements by 1.
  - On a tick with VALUE=0: INTSTAT is set. If PERIODIC=1, VALUE reloads from LOAD. If PERIODIC=0, EN clears and VALUE stays 0.
- Writing EN=0 freezes VALUE and the prescaler. Writing EN=1 resumes from the frozen values.
- TIMER_IRQ = INTSTAT & IE, derived only from flops; there is no combinational path from bus inputs.

## Timing
- Reset values (while HRESET=1 at an edge):
  - CTRL=0, LOAD=0, VALUE=0, PRESCALE=0, INTSTAT=0, prescaler=0.
  - wr_q=0, rd_q=0, so HRDATA=0 and TIMER_IRQ=0.
  - HREADYOUT=1 and HRESP=0 at all times.
- Reset asserted mid-transfer abandons the pending data phase: no write commits.
- Latency:
  - A write is visible to a read issued in the following address phase (back-to-back write→read returns the new value).
  - TIMER_IRQ rises 1 cycle after the underflow tick edge.
- Tick period is PRESCALE+1 cycles. With PRESCALE=0, VALUE changes every cycle while EN=1.
- Simultaneous events, all resolved on the same edge:
  - Bus write to LOAD vs tick: the LOAD write wins (VALUE=new LOAD, prescaler=0).
  - INTSTAT clear vs underflow: set wins.
  - CTRL write vs one-shot EN auto-clear: the bus write wins.
- Wrap-around: the prescaler counter is 8 bits. VALUE never wraps; 0 is handled as underflow.

## Structure
- Shared package timer_pkg: register offset constants (TIMER_CTRL=3'd0 … TIMER_INTSTAT=3'd4), CTRL bit indices, HTRANS encodings.
- Sub-module ahblite_timer_core: prescaler, VALUE counter, INTSTAT logic. Its inputs are the load strobe, the clear strobe and the CTRL fields.
- The top level holds the AHB phase capture, the register decode and the read mux.

## Test plan
- Reset: hold HRESET 2 cycles → HRDATA=0, TIMER_IRQ=0. Reads of 0x00/0x04/0x08/0x0C/0x10 return 0. HREADYOUT=1 throughout.
- Back-to-back accesses: write LOAD=0x10, then immediately read 0x04 and 0x08 → 0x10, 0x10. Read 0x14 → 0.
- One-shot: LOAD=3, PRESCALE=0, CTRL=0x3.
  - VALUE reads 3,2,1,0 on successive cycles.
  - Underflow on the next tick → INTSTAT=1, TIMER_IRQ=1 one cycle later, CTRL.EN=0, VALUE remains 0.
- Periodic with prescale: LOAD=2, PRESCALE=3, CTRL=0x7.
  - VALUE steps every 4 cycles: 2→1→0→2.
  - IRQ pulse sets INTSTAT once per 12 cycles.
  - Write INTSTAT=1 on the same edge as an underflow → INTSTAT stays 1.
- Idle and unselected transfers:
  - HTRANS=IDLE, or HSEL=0, or HREADY=0 with a write → no register changes.
  - HSEL=1 only during HRESET mid-data-phase → write dropped.
